// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the data-memory store buffer.
//   Contents:
//     ADDR_WIDTH / DATA_WIDTH : widths of a buffered store (match Data_Memory)
//     WORD_LSB                : lowest address bit that selects a word
//     sb_entry_t              : one pending store (byte address + data word)
//   Optional feature macro used by the files that import this package:
//     DMEM_SB_FWD_EN (store-to-load forwarding).
package dmem_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int WORD_LSB   = 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_fifo.sv
// sb_fifo
//   Circular storage for pending stores: head/tail pointers, occupancy
//   count, per-entry valid bits and a full read-out of every slot so the
//   top level can run its address compare.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     push          : write push_entry at tail this edge
//     push_entry    : store to enqueue
//     pop           : retire the head entry this edge
//     head_entry    : oldest entry (next to drain)
//     entries       : all slots, indexed by physical position
//     valid         : per-slot occupied flag
//     head          : physical index of the oldest entry
//     count         : number of occupied slots (0..DEPTH)
//   Feature macro DMEM_SB_FWD_EN has no effect inside this block.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head_entry,
    output sb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PW-1:0]    head,
    output logic [PW:0]      count
);

    logic [PW-1:0] tail;

    // Payload storage carries no reset; the valid bits alone say what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // Pointers are power-of-two wide, so plain increment wraps.
            if (pop) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            // Placed after the pop clear: when full, push and pop hit the
            // same slot and the new entry must stay valid.
            if (push) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry = entries[head];

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write buffer between the core load/store path and a single-port
//   Data_Memory. Stores retire in one cycle into a FIFO and drain on cycles
//   when no load needs the memory port; loads read memory combinationally
//   or, with forwarding, take data from the youngest matching entry.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     cpu_we, cpu_re      : store / load request (mutually exclusive)
//     cpu_addr, cpu_wdata : byte address (bits [1:0] ignored), store data
//     cpu_rdata           : load data, valid when cpu_re && !cpu_stall
//     cpu_stall           : request not taken this cycle
//     mem_we, mem_a,
//     mem_di, mem_rd      : Data_Memory port (rd is combinational)
//     sb_empty, sb_count  : occupancy status
//   Macro DMEM_SB_FWD_EN: when defined, loads hitting a pending store are
//   forwarded from the buffer; when undefined, such loads stall until the
//   matching stores have drained.
module dmem_store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SB_DEPTH   = 4,
    localparam int CW        = $clog2(SB_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_we,
    input  logic                  cpu_re,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_di,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  sb_empty,
    output logic [CW-1:0]         sb_count
);
    import dmem_pkg::*;

    localparam int PW = $clog2(SB_DEPTH);

    sb_entry_t             head_entry;
    sb_entry_t             entries [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid;
    logic [PW-1:0]         head;
    logic [CW-1:0]         count;

    logic                  load;
    logic                  empty;
    logic                  full;
    logic                  match;
    logic                  fwd_hit;
    logic                  hold;
    logic                  drain;
    logic                  push;
    logic [PW-1:0]         idx;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  unused_bits;

    // A simultaneous store wins, so the load side is masked off.
    assign load  = cpu_re && !cpu_we;
    assign empty = (count == '0);
    assign full  = (count == CW'(SB_DEPTH));

    // Walk oldest to youngest; the last hit seen is the youngest match.
    always_comb begin
        match    = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] &&
                entries[idx].addr[ADDR_WIDTH-1:WORD_LSB] == cpu_addr[ADDR_WIDTH-1:WORD_LSB]) begin
                match = 1'b1;
`ifdef DMEM_SB_FWD_EN
                fwd_data = entries[idx].data;
`endif
            end
        end
    end

    always_comb begin
`ifdef DMEM_SB_FWD_EN
        fwd_hit = load && match;
        hold    = 1'b0;
`else
        // No forwarding: a load to a pending address waits for it to drain.
        fwd_hit = 1'b0;
        hold    = load && match;
`endif
        // A load that reads memory owns the port, unless the buffer is full.
        drain     = !rst && !empty && (full || !load || fwd_hit || hold);
        cpu_stall = !rst && load && (hold || (full && !fwd_hit));
        push      = !rst && cpu_we && !cpu_stall;
    end

    always_comb begin
        mem_we    = drain;
        mem_a     = drain ? head_entry.addr : cpu_addr;
        mem_di    = drain ? head_entry.data : '0;
        cpu_rdata = fwd_hit ? fwd_data : mem_rd;
        sb_empty  = rst || empty;
        sb_count  = rst ? '0 : count;
    end

    // Address byte-offset bits are carried but never compared.
    always_comb begin
        unused_bits = ^cpu_addr[WORD_LSB-1:0];
        for (int i = 0; i < SB_DEPTH; i++) begin
            unused_bits = unused_bits ^ (^entries[i]);
        end
    end

    sb_fifo #(
        .DEPTH (SB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{addr: cpu_addr, data: cpu_wdata}),
        .pop        (drain),
        .head_entry (head_entry),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    a_no_we_and_re: assert property (@(posedge clk) disable iff (rst) !(cpu_we && cpu_re));
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !drain));

endmodule
